axi_mm_read_slave: RTL

AXI_MM_READ_SLAVE -- requirements
Module: axi_mm_read_slave

---
 rtl/axi_mm_read_slave.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/axi_mm_read_slave.sv
// AXI4 memory-mapped read slave over a word-addressed backing store: one burst at a time,
// first beat RD_LATENCY cycles after AR, then back-to-back beats while rready holds.
module axi_mm_read_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 1024,
  parameter int RD_LATENCY = 2
) (
  input  logic                         axi_aclk,
  input  logic                         axi_resetn,
  input  logic [ADDR_WIDTH-1:0]        araddr,
  input  logic [7:0]                   arlen,
  input  logic [2:0]                   arsize,
  input  logic [1:0]                   arburst,
  input  logic [2:0]                   arprot,
  input  logic [3:0]                   arcache,
  input  logic                         arvalid,
  output logic                         arready,
  output logic [DATA_WIDTH-1:0]        rdata,
  output logic [1:0]                   rresp,
  output logic                         rlast,
  output logic                         rvalid,
  input  logic                         rready,
  input  logic                         init_we,
  input  logic [$clog2(MEM_DEPTH)-1:0] init_addr,
  input  logic [31:0]                  init_data
);

  localparam int IDX_W = ADDR_WIDTH - 2;
  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [7:0]              len_q;
  logic [7:0]              beat_q;
  logic [2:0]              size_q;
  logic [1:0]              burst_q;
  logic [3:0]              wait_q;

  logic [DATA_WIDTH-1:0]   mem [MEM_DEPTH];

  logic [ADDR_WIDTH-1:0]   next_addr;
  logic [ADDR_WIDTH-1:0]   ld_addr;
  logic [2:0]              ld_size;
  logic [1:0]              ld_burst;
  logic                    ld_last;
  logic [IDX_W-1:0]        ld_idx;
  logic                    ld_ok;
  logic [DATA_WIDTH-1:0]   ld_data;
  logic [1:0]              ld_resp;
  logic                    unused_bits;

  // Backing store has no reset so contents survive axi_resetn.
  always_ff @(posedge axi_aclk) begin
    if (init_we) mem[init_addr] <= init_data;
  end

  assign next_addr = (burst_q == 2'b00) ? addr_q : addr_q + ADDR_WIDTH'(4);

  // Describes the beat about to be loaded into the R registers: straight from the AR
  // channel when RD_LATENCY is 0, otherwise the current or following burst address.
  always_comb begin
    ld_addr  = addr_q;
    ld_size  = size_q;
    ld_burst = burst_q;
    ld_last  = (beat_q == len_q);
    if (state == IDLE) begin
      ld_addr  = araddr;
      ld_size  = arsize;
      ld_burst = arburst;
      ld_last  = (arlen == 8'd0);
    end else if (state == BURST) begin
      ld_addr = next_addr;
      ld_last = ((beat_q + 8'd1) == len_q);
    end
  end

  assign ld_idx  = ld_addr[ADDR_WIDTH-1:2];
  assign ld_ok   = ({1'b0, ld_idx} < (IDX_W+1)'(MEM_DEPTH)) && (ld_size == 3'd2) && (ld_burst != 2'b11);
  assign ld_data = ld_ok ? mem[ld_idx[MEM_AW-1:0]] : '0;
  assign ld_resp = ld_ok ? RESP_OKAY : RESP_SLVERR;

  assign unused_bits = ^{arprot, arcache, ld_addr[1:0]};

  always_ff @(posedge axi_aclk) begin
    if (!axi_resetn) begin
      state   <= IDLE;
      arready <= 1'b0;
      rvalid  <= 1'b0;
      rlast   <= 1'b0;
      rresp   <= RESP_OKAY;
      rdata   <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      burst_q <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          arready <= 1'b1;
          if (arvalid && arready) begin
            arready <= 1'b0;
            addr_q  <= araddr;
            len_q   <= arlen;
            size_q  <= arsize;
            burst_q <= arburst;
            beat_q  <= '0;
            if (RD_LATENCY == 0) begin
              state  <= BURST;
              rvalid <= 1'b1;
              rdata  <= ld_data;
              rresp  <= ld_resp;
              rlast  <= ld_last;
            end else begin
              state  <= WAIT;
              wait_q <= 4'(RD_LATENCY - 1);
            end
          end
        end
        WAIT: begin
          if (wait_q == 4'd0) begin
            state  <= BURST;
            rvalid <= 1'b1;
            rdata  <= ld_data;
            rresp  <= ld_resp;
            rlast  <= ld_last;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        BURST: begin
          if (rready) begin
            if (rlast) begin
              state   <= IDLE;
              rvalid  <= 1'b0;
              rlast   <= 1'b0;
              arready <= 1'b1;
            end else begin
              // Next beat is loaded on the same edge as the handshake: no bubble.
              beat_q <= beat_q + 8'd1;
              addr_q <= next_addr;
              rdata  <= ld_data;
              rresp  <= ld_resp;
              rlast  <= ld_last;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
